axi_sram_slave: RTL

AXI3-style slave that terminates the bus produced by the core's memory-bus-to-AXI master and drives a single-port synchronous SRAM that holds both instructions and data. It serves one transaction at a time, with writes taking priority over reads. Bursts of FIXED or INCR type up to 16 beats are serviced at word granularity. Byte strobes, IDs and SLVERR on out-of-range addresses are honoured.

---
 rtl/axi_sram_slave_pkg.sv | 21 ++
 rtl/axi_sram_addr_gen.sv | 51 +++++
 rtl/axi_sram_slave.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_pkg.sv
// Shared constants and state encoding for the AXI3 SRAM slave.
package axi_sram_slave_pkg;

  localparam int unsigned BEAT_W = 5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_DATA  = 3'd1,
    ST_WR_RESP  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_SEND  = 3'd4
  } state_e;

endpackage

// File: rtl/axi_sram_addr_gen.sv
// Burst address generator: word address, remaining beats and range error,
// loaded at the address handshake and stepped once per data beat.
module axi_sram_addr_gen
  import axi_sram_slave_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           SRAM_AW    = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            len,
  input  logic [1:0]            burst,
  input  logic                  step,
  output logic [SRAM_AW-1:0]    word_addr,
  output logic [BEAT_W-1:0]     beats_left,
  output logic                  last_c,
  output logic                  err
);

  logic [ADDR_WIDTH-1:0] offset;
  logic                  incr_q;
  logic                  unused_offset;

  assign offset        = addr - BASE_ADDR;
  assign unused_offset = ^offset[1:0];
  assign last_c        = (beats_left == BEAT_W'(1));

  // WRAP is serviced as INCR; the word address wraps naturally at the SRAM depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_addr  <= '0;
      beats_left <= '0;
      incr_q     <= 1'b0;
      err        <= 1'b0;
    end else if (load) begin
      word_addr  <= offset[SRAM_AW+1:2];
      beats_left <= BEAT_W'(len) + BEAT_W'(1);
      incr_q     <= (burst == BURST_INCR) || (burst == BURST_WRAP);
      err        <= |offset[ADDR_WIDTH-1:SRAM_AW+2];
    end else if (step) begin
      if (incr_q) begin
        word_addr <= word_addr + SRAM_AW'(1);
      end
      beats_left <= beats_left - BEAT_W'(1);
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave fronting a single-port synchronous SRAM; one transaction at a
// time, writes win over reads, FIXED/INCR bursts at word granularity.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           ID_WIDTH   = 6,
  parameter int unsigned           STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned           SRAM_AW    = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [3:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic [ID_WIDTH-1:0]   AWID,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WLAST,
  input  logic [ID_WIDTH-1:0]   WID,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic [ID_WIDTH-1:0]   BID,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [3:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic [ID_WIDTH-1:0]   RID,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  sram_en,
  output logic [STRB_WIDTH-1:0] sram_we,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] id_q;
  logic                ag_load, ag_step, ag_last_c, ag_err;
  logic [SRAM_AW-1:0]  ag_addr;
  logic [BEAT_W-1:0]   ag_beats;
  logic                unused_inputs;

  assign unused_inputs = ^{AWSIZE, ARSIZE, WLAST, WID, ag_beats};
  assign ag_load       = (state_q == ST_IDLE) && (AWVALID || ARVALID);
  assign sram_addr     = ag_addr;

  axi_sram_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .SRAM_AW   (SRAM_AW),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .clk       (ACLK),
    .rst       (ARESET),
    .load      (ag_load),
    .addr      (AWVALID ? AWADDR : ARADDR),
    .len       (AWVALID ? AWLEN : ARLEN),
    .burst     (AWVALID ? AWBURST : ARBURST),
    .step      (ag_step),
    .word_addr (ag_addr),
    .beats_left(ag_beats),
    .last_c    (ag_last_c),
    .err       (ag_err)
  );

  // State and transaction ID registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ag_load) begin
        id_q <= AWVALID ? AWID : ARID;
      end
    end
  end

  // Next state and channel/SRAM outputs; READYs are gated so reset drops them at once
  always_comb begin
    state_d    = state_q;
    AWREADY    = 1'b0;
    ARREADY    = 1'b0;
    WREADY     = 1'b0;
    BVALID     = 1'b0;
    BRESP      = RESP_OKAY;
    BID        = '0;
    RVALID     = 1'b0;
    RDATA      = '0;
    RRESP      = RESP_OKAY;
    RLAST      = 1'b0;
    RID        = '0;
    sram_en    = 1'b0;
    sram_we    = '0;
    sram_wdata = '0;
    ag_step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        AWREADY = !ARESET;
        ARREADY = !ARESET && !AWVALID;
        if (AWVALID) begin
          state_d = ST_WR_DATA;
        end else if (ARVALID) begin
          state_d = ST_RD_ISSUE;
        end
      end
      ST_WR_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          sram_en    = !ag_err;
          sram_we    = ag_err ? '0 : WSTRB;
          sram_wdata = WDATA;
          ag_step    = 1'b1;
          if (ag_last_c) begin
            state_d = ST_WR_RESP;
          end
        end
      end
      ST_WR_RESP: begin
        BVALID = 1'b1;
        BID    = id_q;
        BRESP  = ag_err ? RESP_SLVERR : RESP_OKAY;
        if (BREADY) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_ISSUE: begin
        sram_en = !ag_err;
        state_d = ST_RD_SEND;
      end
      ST_RD_SEND: begin
        RVALID = 1'b1;
        RDATA  = ag_err ? '0 : sram_rdata;
        RRESP  = ag_err ? RESP_SLVERR : RESP_OKAY;
        RLAST  = ag_last_c;
        RID    = id_q;
        if (RREADY) begin
          ag_step = 1'b1;
          state_d = ag_last_c ? ST_IDLE : ST_RD_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
